display_scan_controller: RTL and testbench
==========================================

# display_scan_controller

Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the `top` display path. It owns the refresh sequencing: digit rotation, inter-digit blanking to suppress ghosting, and hex-to-segment decoding. It also accepts new display contents from an upstream producer through a valid/ready handshake and double-buffers them. New contents reach the pins only at a frame boundary, so a frame never shows a mix of old and new values.

## Interface
- `TICKS_PER_DIGIT`, default 100000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_TICKS`, default 1000: cycles at the start of each slot with all anodes off. Must satisfy 1 ≤ BLANK_TICKS < TICKS_PER_DIGIT.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `load_valid` in 1: producer offers new contents.
- `load_ready` out 1: controller can accept contents (shadow buffer empty).
- `digits_in` in 16: four hex nibbles. [3:0] is digit 0 (rightmost, E[0]).
- `dp_in` in 4: decimal point per digit, 1 = lit.
- `blank_in` in 4: per-digit blank, 1 = digit dark (segments and DP off).
- `E` out 4: anode enables, active-low.
- `sevenSeg` out 7: segments {g,f,e,d,c,b,a}, active-low. sevenSeg[0] = a.
- `DP` out 1: decimal point, active-low.
- `frame_start` out 1: one-cycle pulse on the first cycle of digit 0's slot.

## Operation
- Registers:
  - active set {digits, dp, blank}
  - shadow set plus `pending` flag
  - `digit_idx` [1:0]
  - tick counter, width $clog2(TICKS_PER_DIGIT), counting 0..TICKS_PER_DIGIT-1
  - phase state {BLANK, SHOW}
- Load handshake:
  - `load_ready = ~pending`.
  - A transfer occurs on a rising edge with `load_valid & load_ready`. The shadow set is captured and `pending` is set.
  - The producer must hold its data stable while `load_valid` is high and `load_ready` is low.
- Slot sequencing:
  - BLANK state while tick < BLANK_TICKS. SHOW state for the remaining cycles.
  - When the tick reaches TICKS_PER_DIGIT-1, the counter wraps to 0, `digit_idx` increments modulo 4 (3→0), and the state returns to BLANK.
- Commit:
  - On the edge where `digit_idx` wraps 3→0, if `pending` is set, copy shadow to active and clear `pending`.
  - `frame_start` is asserted for that first cycle of the slot.
  - A transfer cannot coincide with a commit, because a commit requires `pending=1`, which forces `load_ready=0`.
- Output decode:
  - BLANK state, or `blank[digit_idx]`=1: E=4'b1111, sevenSeg=7'b1111111, DP=1.
  - Otherwise: E has only bit `digit_idx` low, sevenSeg = hex decode of the active nibble, DP = ~dp[digit_idx].
- Hex decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

## Timing
- Reset (asynchronous assert, synchronous release):
  - active digits=0, active blank=4'b1111, active dp=0
  - pending=0, digit_idx=0, tick=0, state BLANK
  - E=4'b1111, sevenSeg=7'b1111111, DP=1, frame_start=0, load_ready=1
- Outputs are registered and change on the same edge as the state/counter they reflect.
- Frame length is 4×TICKS_PER_DIGIT cycles. `frame_start` period equals the frame length.
- Lit time per slot is TICKS_PER_DIGIT−BLANK_TICKS cycles.
- Latency from transfer to display is at most one frame plus one slot, and at least 1 cycle (a transfer one cycle before the wrap edge).
- The first `frame_start` after reset release occurs TICKS_PER_DIGIT×4 cycles after release, i.e. at the first 3→0 wrap. The reset state itself does not pulse.
- Reset mid-frame or mid-handshake discards shadow and active contents. The display goes dark immediately (asynchronous).

## Structure
- Shared package `display_pkg`:
  - `NUM_DIGITS=4`
  - segment constants `SEG_OFF=7'b1111111`, `AN_OFF=4'b1111`
  - phase enum {BLANK, SHOW}
- Sub-module `hex_to_seg7`: combinational nibble → active-low 7-bit decoder. It is reusable by other display blocks.

## Test plan
All scenarios use TICKS_PER_DIGIT=8 and BLANK_TICKS=2.
- Reset: hold `rst_n`=0 → E=1111, sevenSeg=1111111, DP=1, load_ready=1. After release, the display stays dark for the whole first frame (active blank=1111).
- Basic load: transfer digits_in=16'h1234, dp_in=4'b0001, blank_in=0 → after the next wrap:
  - digit 0 slot: E=1110, sevenSeg=0011001, DP=0 on slot ticks 2–7, dark on ticks 0–1.
  - digit 1 slot: E=1101, sevenSeg=0110000, DP=1.
- Backpressure: a second `load_valid` of 16'hABCD right after the first transfer → load_ready=0 until the commit edge, then it is accepted. 16'h1234 shows for exactly one frame before ABCD.
- Per-digit blank: blank_in=4'b0100 with 16'h8888 → E never equals 1011. Other slots show 0000000.
- Frame cadence: `frame_start` pulses exactly every 32 cycles. `digit_idx` sequence is 0,1,2,3,0.
- Reset mid-frame: assert `rst_n`=0 during the digit-2 SHOW phase with a transfer pending → outputs go dark asynchronously. After release, pending=0, load_ready=1, and the old contents are never displayed.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display definitions: digit count, "all off" pin levels, scan phase
// and the buffered display-contents record.
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  // BLANK = anodes forced off at slot start (anti-ghosting), SHOW = digit lit.
  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

  // One full set of display contents (active or shadow copy).
  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_set_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg7 (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph table: lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    seg_o = 7'b1111111;
    case (nibble_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit common-anode scan controller. Rotates digit slots, blanks the
// start of each slot, and double-buffers producer contents so they only
// reach the pins at a frame boundary.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  E,
  output logic [6:0]  sevenSeg,
  output logic        DP,
  output logic        frame_start
);

  localparam int             CW         = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0]  TICK_LAST  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0]  TICK_BLANK = CW'(BLANK_TICKS);

  disp_set_t      act_q, act_d;
  disp_set_t      shd_q, shd_d;
  logic           pend_q, pend_d;
  logic [1:0]     idx_q, idx_d;
  logic [CW-1:0]  tick_q, tick_d;
  phase_e         phase_q, phase_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic           fs_q, fs_d;

  logic           slot_end, frame_wrap, xfer, commit, dark;
  logic [3:0]     nib;
  logic [6:0]     seg_dec;

  // Next-state: slot timing, handshake/commit, and decode of the next cycle's
  // pins so the registered outputs line up with the state they reflect.
  always_comb begin
    slot_end   = (tick_q == TICK_LAST);
    frame_wrap = slot_end && (idx_q == 2'd3);
    tick_d     = slot_end ? '0 : tick_q + CW'(1);
    idx_d      = slot_end ? idx_q + 2'd1 : idx_q;

    phase_d = phase_q;
    if (slot_end)
      phase_d = BLANK;
    else if (phase_q == BLANK && tick_d == TICK_BLANK)
      phase_d = SHOW;

    // A commit needs pend_q=1, which holds load_ready low, so the two never
    // happen on the same edge.
    xfer   = load_valid && !pend_q;
    commit = frame_wrap && pend_q;

    act_d  = commit ? shd_q : act_q;
    shd_d  = xfer ? '{digits: digits_in, dp: dp_in, blank: blank_in} : shd_q;
    pend_d = xfer ? 1'b1 : (commit ? 1'b0 : pend_q);

    nib  = act_d.digits[{idx_d, 2'b00} +: 4];
    dark = (phase_d == BLANK) || act_d.blank[idx_d];

    an_d  = dark ? AN_OFF  : ~(4'b0001 << idx_d);
    seg_d = dark ? SEG_OFF : seg_dec;
    dp_d  = dark ? 1'b1    : ~act_d.dp[idx_d];
    fs_d  = frame_wrap;
  end

  hex_to_seg7 u_dec (
    .nibble_i (nib),
    .seg_o    (seg_dec)
  );

  // State and registered pins; reset discards both buffers and darkens the display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q   <= '{digits: '0, dp: '0, blank: '1};
      shd_q   <= '0;
      pend_q  <= 1'b0;
      idx_q   <= 2'd0;
      tick_q  <= '0;
      phase_q <= BLANK;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign load_ready  = ~pend_q;
  assign E           = an_q;
  assign sevenSeg    = seg_q;
  assign DP          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: directed load/backpressure/blank/reset
// scenarios plus randomized producer traffic, checked every cycle against a
// cycle-count based reference model.
module tb_display_scan_controller;

  localparam int T = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * T;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  E;
  logic [6:0]  sevenSeg;
  logic        DP;
  logic        frame_start;

  display_scan_controller #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_in    (blank_in),
    .E           (E),
    .sevenSeg    (sevenSeg),
    .DP          (DP),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: n = edges since reset release; slot/tick follow by division.
  int          n;
  int          cyc;
  int          last_fs;
  logic [15:0] m_dig, s_dig;
  logic [3:0]  m_dp, s_dp, m_bl, s_bl;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic m_reset();
    n = 0; m_dig = '0; m_dp = '0; m_bl = 4'hF; m_pend = 1'b0; last_fs = -1;
    s_dig = '0; s_dp = '0; s_bl = '0;
  endtask

  task automatic check_outputs();
    int         tick, idx;
    bit         dark;
    logic [3:0] eE;
    logic [6:0] eSeg;
    logic       eDP;
    tick = n % T;
    idx  = (n / T) % 4;
    dark = (tick < B) || m_bl[idx];
    eE   = dark ? 4'hF : ~(4'b0001 << idx);
    eSeg = dark ? 7'h7F : seg_ref(m_dig[idx*4 +: 4]);
    eDP  = dark ? 1'b1 : ~m_dp[idx];
    chk("E", E, eE);
    chk("sevenSeg", sevenSeg, eSeg);
    chk("DP", DP, eDP);
    chk("frame_start", frame_start, (n > 0 && n % FRAME == 0));
    chk("load_ready", load_ready, !m_pend);
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, FRAME);
      last_fs = cyc;
    end
  endtask

  // One clock: drive inputs, advance model on the edge, check at negedge.
  task automatic step(input bit v, input logic [15:0] d, input logic [3:0] p,
                      input logic [3:0] b, output bit took);
    load_valid = v; digits_in = d; dp_in = p; blank_in = b;
    @(posedge clk);
    took = v && !m_pend;
    n++; cyc++;
    if (n % FRAME == 0 && m_pend) begin
      m_dig = s_dig; m_dp = s_dp; m_bl = s_bl; m_pend = 1'b0;
    end
    if (took) begin
      s_dig = d; s_dp = p; s_bl = b; m_pend = 1'b1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int k);
    bit t;
    for (int i = 0; i < k; i++)
      step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom), t);
  endtask

  // Offer contents and hold them until taken (bounded).
  task automatic offer(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    bit t = 1'b0;
    for (int i = 0; i < 3 * FRAME && !t; i++) step(1'b1, d, p, b, t);
    chk("offer_accepted", t, 1'b1);
  endtask

  task automatic idle_until_phase(input int ph);
    for (int i = 0; i < FRAME && (n % FRAME) != ph; i++) idle(1);
    chk("phase_reached", n % FRAME, ph);
  endtask

  initial begin
    bit          hold, t;
    logic [15:0] rd;
    logic [3:0]  rp, rb;
    cyc = 0;
    rst_n = 1'b0; load_valid = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_E", E, 4'hF);
    chk("rst_seg", sevenSeg, 7'h7F);
    chk("rst_DP", DP, 1'b1);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;

    // Basic load then immediate backpressured second load.
    idle(5);
    offer(16'h1234, 4'b0001, 4'b0000);
    offer(16'hABCD, 4'b0000, 4'b0000);
    chk("abcd_accept_phase", n % FRAME, 1);
    idle(2 * FRAME);

    // Per-digit blank.
    offer(16'h8888, 4'b0000, 4'b0100);
    idle(3 * FRAME);

    // Randomized producer traffic; data held while offered and not taken.
    hold = 1'b0; rd = '0; rp = '0; rb = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hold) begin
        rd = 16'($urandom);
        rp = 4'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
        hold = ($urandom_range(0, 3) == 0);
      end
      step(hold, rd, rp, rb, t);
      if (t) hold = 1'b0;
    end

    // Reset during digit-2 SHOW with a transfer pending.
    for (int i = 0; i < 2 * FRAME && m_pend; i++) idle(1);
    idle_until_phase(1);
    offer(16'h5A5A, 4'hF, 4'b0000);
    idle_until_phase(20);
    chk("pending_before_rst", load_ready, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_E", E, 4'hF);
    chk("mid_rst_seg", sevenSeg, 7'h7F);
    chk("mid_rst_DP", DP, 1'b1);
    chk("mid_rst_ready", load_ready, 1'b1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    check_outputs();
    idle(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
